// File: rtl/mem_reinit_ctrl_if.sv
// Stream-source and RAM-port bundle shared by the reload controller and its surroundings.
// The master side is the controller; the slave side is the word source plus the RAM.
interface mem_reinit_ctrl_if #(
  parameter int WID_MEM = 32,
  parameter int AW      = 11
) ();
  logic               s_valid;
  logic [WID_MEM-1:0] s_data;
  logic               s_ready;
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [WID_MEM-1:0] mem_din;
  logic [AW-1:0]      mem_raddr;
  logic [WID_MEM-1:0] mem_dout;

  modport master (
    input  s_valid, s_data, mem_dout,
    output s_ready, mem_we, mem_waddr, mem_din, mem_raddr
  );

  modport slave (
    output s_valid, s_data, mem_dout,
    input  s_ready, mem_we, mem_waddr, mem_din, mem_raddr
  );
endinterface

// File: rtl/mem_reinit_ctrl.sv
// Reloads a dual-port RAM from a valid/ready word stream, then reads it all back and
// compares additive checksums of the written and the read-back data.
module mem_reinit_ctrl #(
  parameter int WID_MEM   = 32,
  parameter int DEPTH_MEM = 2048,
  parameter int AW        = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  mem_reinit_ctrl_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [WID_MEM-1:0] checksum
);

  localparam logic [AW-1:0]      LAST_ADDR = AW'(DEPTH_MEM - 1);
  localparam logic [AW-1:0]      ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0]      ADDR_ZERO = {AW{1'b0}};
  localparam logic [WID_MEM-1:0] WORD_ZERO = {WID_MEM{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READ  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_CMP   = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [AW-1:0]      wcnt_r;
  logic [AW-1:0]      rcnt_r;
  logic [WID_MEM-1:0] wsum_r;
  logic [WID_MEM-1:0] rsum_r;
  logic [WID_MEM-1:0] checksum_r;
  logic               rd_vld_r;
  logic               pass_r;
  logic               accept_s;

  // Next-state decode plus the combinational stream/RAM strobes and status outputs.
  always_comb begin
    state_s       = state_r;
    accept_s      = 1'b0;
    bus.s_ready   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_waddr = ADDR_ZERO;
    bus.mem_din   = WORD_ZERO;
    bus.mem_raddr = ADDR_ZERO;
    busy          = 1'b0;
    done          = 1'b0;
    pass          = pass_r;
    checksum      = checksum_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        busy        = 1'b1;
        bus.s_ready = 1'b1;
        accept_s    = bus.s_valid;
        if (accept_s) begin
          bus.mem_we    = 1'b1;
          bus.mem_waddr = wcnt_r;
          bus.mem_din   = bus.s_data;
          if (wcnt_r == LAST_ADDR) begin
            state_s = ST_READ;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_READ: begin
        busy          = 1'b1;
        bus.mem_raddr = rcnt_r;
        if (rcnt_r == LAST_ADDR) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_FLUSH: begin
        busy    = 1'b1;
        state_s = ST_CMP;
      end
      ST_CMP: begin
        // Result is presented in the done cycle itself, then held by the registers.
        busy     = 1'b1;
        done     = 1'b1;
        pass     = (wsum_r == rsum_r);
        checksum = wsum_r;
        state_s  = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register, address counters and checksum accumulators.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      wcnt_r     <= ADDR_ZERO;
      rcnt_r     <= ADDR_ZERO;
      wsum_r     <= WORD_ZERO;
      rsum_r     <= WORD_ZERO;
      checksum_r <= WORD_ZERO;
      rd_vld_r   <= 1'b0;
      pass_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      rd_vld_r <= (state_r == ST_READ);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            wcnt_r <= ADDR_ZERO;
            rcnt_r <= ADDR_ZERO;
            wsum_r <= WORD_ZERO;
            rsum_r <= WORD_ZERO;
            pass_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            wsum_r <= wsum_r + bus.s_data;
            wcnt_r <= wcnt_r + ADDR_ONE;
          end
        end
        ST_READ: begin
          rcnt_r <= rcnt_r + ADDR_ONE;
        end
        ST_CMP: begin
          pass_r     <= (wsum_r == rsum_r);
          checksum_r <= wsum_r;
        end
        default: begin
        end
      endcase
      // Read data lags its address by one cycle; FLUSH picks up the last word.
      if (rd_vld_r) begin
        rsum_r <= rsum_r + bus.mem_dout;
      end
    end
  end

endmodule

// File: doc/mem_reinit_ctrl.md
Name: mem_reinit_ctrl

Overview:
- Sequencer that reloads a simple dual-port block RAM (registered read, 1-cycle read latency) from a streamed word source, then reads the full array back and verifies it.
- Write phase: consumes DEPTH_MEM words over a valid/ready stream and drives them to sequential write addresses while accumulating an additive checksum.
- Readback phase: sweeps every read address and accumulates a second checksum, then reports pass/fail.
- Sits between the bitstream-reinit word source and one memory instance; owns both RAM address ports for the whole operation.

Parameters:
- WID_MEM, 32, data width of RAM word, stream data and checksums.
- DEPTH_MEM, 2048, number of RAM words; power of two, at least 2.
- AW, 11, address width; equals log2(DEPTH_MEM).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a reload; sampled only in IDLE.
- s_valid  in  1  source word valid.
- s_data  in  WID_MEM  source word.
- s_ready  out  1  controller accepts s_data this cycle.
- mem_we  out  1  RAM write enable.
- mem_waddr  out  AW  RAM write address.
- mem_din  out  WID_MEM  RAM write data.
- mem_raddr  out  AW  RAM read address.
- mem_dout  in  WID_MEM  RAM read data; valid the cycle after mem_raddr is presented.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when verification completes.
- pass  out  1  write checksum equals read checksum; valid from done until the next start.
- checksum  out  WID_MEM  write-phase checksum; held after done.

Behaviour:
- Reset (async assert, any state): state=IDLE; all counters and checksums 0; s_ready=0, mem_we=0, mem_waddr=0, mem_din=0, mem_raddr=0, busy=0, done=0, pass=0, checksum=0.
- A reset asserted mid-LOAD or mid-READ aborts the operation; done does not pulse. RAM contents are undefined after an aborted load.
- States: IDLE -> LOAD -> READ -> FLUSH -> CMP -> IDLE.
- IDLE:
  - s_ready=0, mem_we=0.
  - start=1 -> LOAD; clear wcnt, rcnt, wsum, rsum and pass.
- LOAD:
  - s_ready=1 combinationally.
  - Accept condition is s_valid & s_ready.
  - On accept: mem_we=1, mem_waddr=wcnt and mem_din=s_data, all combinational in the same cycle. At the edge: wsum += s_data (mod 2^WID_MEM) and wcnt++.
  - No accept: mem_we=0; state held indefinitely.
  - Accept with wcnt==DEPTH_MEM-1 -> READ next cycle.
- READ:
  - mem_raddr=rcnt; rcnt increments every cycle with no stalls.
  - rd_vld register is set one cycle after each address issue; while rd_vld=1, rsum += mem_dout.
  - After address DEPTH_MEM-1 is issued -> FLUSH.
  - The first read is issued the cycle after the last write edge, so no read-during-write collision occurs.
- FLUSH: one cycle that captures the final mem_dout into rsum -> CMP.
- CMP:
  - pass <= (wsum==rsum); checksum <= wsum; done=1 for this cycle only -> IDLE.
  - pass and checksum hold until the next accepted start.
- start is ignored while busy=1.
- s_valid is ignored outside LOAD.
- Address counters never wrap inside an operation; exactly DEPTH_MEM writes and DEPTH_MEM reads occur per operation.
- Latency with continuous s_valid, start at cycle 0: LOAD spans cycles 1..DEPTH_MEM, READ spans DEPTH_MEM+1..2·DEPTH_MEM, FLUSH is 2·DEPTH_MEM+1, done is high in cycle 2·DEPTH_MEM+2 (4098 for the defaults).
- Checksum overflow wraps silently; there is no carry out.

Test Plan:
- Defaults, continuous stream s_data = addr+1 -> 2048 writes to addresses 0..2047 in order; done in cycle 4098; pass=1; checksum=0x00200400.
- Backpressure: s_valid toggles 1,0,1,0… -> mem_we only on valid cycles, waddr sequence gap-free; done is delayed by exactly the idle count; pass=1.
- Fault: RAM model flips bit 0 at address 5 on read -> pass=0 at done, checksum still 0x00200400.
- start pulsed during READ, and s_valid high in IDLE -> no state change, s_ready=0, no extra writes.
- reset asserted at write 1000 -> outputs 0 immediately (async), no done pulse; a new start completes normally with pass=1.
- Overflow: all words 0xFFFFFFFF -> checksum=0xFFFFF800 (wrapped), pass=1.
